i2s_receiver: RTL and testbench

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/i2s_receiver.sv | 154 +++++++++++++++
 tb/tb_i2s_receiver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// I2S receiver: samples sclk/lrclk/sd in the clk domain and presents left/right pairs.
// Slot-length checking on frame_err is built only when I2S_RX_FRAME_ERR_EN is defined.

module i2s_receiver #(
   parameter int WIDTH     = 24,
   parameter int SLOT_BITS = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             sclk,
   input  logic             lrclk,
   input  logic             sd,
   output logic [WIDTH-1:0] sample_left,
   output logic [WIDTH-1:0] sample_right,
   output logic             sample_valid,
   output logic             frame_err
);

   // state | meaning
   // HUNT  | discarding data until a change edge to lrclk = 0
   // LEFT  | collecting left slot bits
   // RIGHT | collecting right slot bits
   typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

   localparam int              CW      = $clog2(SLOT_BITS + 2);
   localparam logic [CW-1:0]   CNT_MAX = CW'(SLOT_BITS + 1);

   logic             sclk_s1, sclk_s2, sclk_s3;
   logic             lr_s1, lr_s2, sd_s1, sd_s2;
   logic             rise_q, lr_q, sd_q;
   logic             lr_prev;
   logic             change;
   state_t           state;
   logic [WIDTH-1:0] word, word_next, hold, right_word;
   logic [CW-1:0]    cnt;
   logic             pair_pend;
`ifdef I2S_RX_FRAME_ERR_EN
   logic             err_pend;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         lr_s1   <= 1'b0;
         lr_s2   <= 1'b0;
         sd_s1   <= 1'b0;
         sd_s2   <= 1'b0;
         rise_q  <= 1'b0;
         lr_q    <= 1'b0;
         sd_q    <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         lr_s1   <= lrclk;
         lr_s2   <= lr_s1;
         sd_s1   <= sd;
         sd_s2   <= sd_s1;
         // Registering the edge and its samples sets the 4-clk valid latency
         rise_q  <= sclk_s2 & ~sclk_s3;
         lr_q    <= lr_s2;
         sd_q    <= sd_s2;
      end
   end

   assign change = rise_q && (lr_q != lr_prev);

   // Bit n of a slot lands at word[WIDTH-1-n]; later bits fall off the end
   always_comb begin
      word_next = word;
      for (int i = 0; i < WIDTH; i++) begin
         if (int'(cnt) == WIDTH - 1 - i) word_next[i] = sd_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= HUNT;
         lr_prev    <= 1'b0;
         word       <= '0;
         cnt        <= '0;
         hold       <= '0;
         right_word <= '0;
         pair_pend  <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
         err_pend   <= 1'b0;
`endif
      end else begin
         pair_pend <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
         err_pend  <= 1'b0;
`endif
         if (rise_q) begin
            lr_prev <= lr_q;
            case (state)
               HUNT: begin
                  if (change && !lr_q) begin
                     state <= LEFT;
                     word  <= '0;
                     cnt   <= '0;
                  end
               end
               LEFT, RIGHT: begin
                  if (change) begin
                     word <= '0;
                     cnt  <= '0;
`ifdef I2S_RX_FRAME_ERR_EN
                     err_pend <= (int'(cnt) + 1 != SLOT_BITS);
`endif
                     if (state == LEFT) begin
                        hold  <= word_next;
                        state <= RIGHT;
                     end else begin
                        right_word <= word_next;
                        pair_pend  <= 1'b1;
                        state      <= LEFT;
                     end
                  end else begin
                     word <= word_next;
                     if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sample_left  <= '0;
         sample_right <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= pair_pend;
         if (pair_pend) begin
            sample_left  <= hold;
            sample_right <= right_word;
         end
      end
   end

`ifdef I2S_RX_FRAME_ERR_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) frame_err <= 1'b0;
      else       frame_err <= err_pend;
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: serialises I2S frames and scoreboards the sample pairs.

module tb_i2s_receiver;

   localparam int WIDTH     = 24;
   localparam int SLOT_BITS = 32;
`ifdef I2S_RX_FRAME_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             sclk = 1'b0;
   logic             lrclk = 1'b0;
   logic             sd = 1'b0;
   logic [WIDTH-1:0] sample_left, sample_right;
   logic             sample_valid, frame_err;

   i2s_receiver #(.WIDTH(WIDTH), .SLOT_BITS(SLOT_BITS)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .sclk         (sclk),
      .lrclk        (lrclk),
      .sd           (sd),
      .sample_left  (sample_left),
      .sample_right (sample_right),
      .sample_valid (sample_valid),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] l_tx;
      logic [31:0] r_tx;
      int          nbits;
      logic [23:0] l_exp;
      logic [23:0] r_exp;
   } vec_t;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
   } pair_t;

   vec_t        vecs[6];
   pair_t       exp_q[$];
   logic [23:0] obs_l[$];
   logic [23:0] obs_r[$];
   int          nchecks = 0;
   int          nerrs = 0;
   int          err_cnt = 0;
   int          run = 0;
   int          max_run = 0;
   int          obs_idx = 0;
   int          err_base = 0;
   logic        carry = 1'b0;

   // Output monitor: records every presented pair and counts frame_err pulses
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sample_valid === 1'b1) begin
            obs_l.push_back(sample_left);
            obs_r.push_back(sample_right);
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (frame_err === 1'b1) err_cnt++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrs++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic send_bit(input logic lr, input logic b);
      sclk  = 1'b0;
      lrclk = lr;
      sd    = b;
      repeat (8) @(negedge clk);
      sclk  = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // One lrclk period: the first bit is the previous word's LSB (one-bit delay)
   task automatic send_slot(input logic lr, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) send_bit(lr, (i == 0) ? carry : d[32-i]);
      carry = d[32-n];
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
      send_slot(1'b0, l, n);
      send_slot(1'b1, r, n);
   endtask

   task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
      pair_t p;
      send_frame({l, 8'h00}, {r, 8'h00}, 32);
      p.l = l;
      p.r = r;
      exp_q.push_back(p);
   endtask

   task automatic start_stream();
      carry = 1'b0;
      send_slot(1'b1, 32'h0, 32);
   endtask

   task automatic flush();
      send_bit(1'b0, carry);
      send_bit(1'b0, 1'b0);
      repeat (10) @(negedge clk);
   endtask

   task automatic mark_phase();
      err_base = err_cnt;
      obs_idx  = obs_l.size();
      exp_q.delete();
   endtask

   task automatic rst_cycle();
      @(negedge clk);
      rstn  = 1'b0;
      sclk  = 1'b0;
      lrclk = 1'b0;
      sd    = 1'b0;
      carry = 1'b0;
      repeat (4) @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      mark_phase();
   endtask

   task automatic drain(input string nm, input int exp_errs);
      pair_t e;
      int    n_obs;
      n_obs = obs_l.size() - obs_idx;
      check({nm, "_pairs"}, n_obs, exp_q.size());
      while (exp_q.size() > 0 && obs_idx < obs_l.size()) begin
         e = exp_q.pop_front();
         check({nm, "_left"}, obs_l[obs_idx], e.l);
         check({nm, "_right"}, obs_r[obs_idx], e.r);
         obs_idx++;
      end
      exp_q.delete();
      check({nm, "_frame_err"}, err_cnt - err_base, exp_errs);
   endtask

   initial begin
      pair_t       p;
      logic [23:0] rl, rr;

      vecs[0] = '{32'h12345600, 32'hABCDEF00, 32, 24'h123456, 24'hABCDEF};
      vecs[1] = '{32'h00000000, 32'hFFFFFF00, 32, 24'h000000, 24'hFFFFFF};
      vecs[2] = '{32'hDEADBEEF, 32'h01234567, 32, 24'hDEADBE, 24'h012345};
      vecs[3] = '{32'h80000000, 32'h7FFFFF00, 32, 24'h800000, 24'h7FFFFF};
      vecs[4] = '{32'h80010000, 32'h7FFF0000, 16, 24'h800100, 24'h7FFF00};
      vecs[5] = '{32'hA5A50000, 32'h5A5A0000, 16, 24'hA5A500, 24'h5A5A00};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_left", sample_left, 0);
      check("rst_right", sample_right, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_frame_err", frame_err, 0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_left", sample_left, 0);
      check("idle_valid", sample_valid, 0);
      mark_phase();

      // Table of frames, including 16-bit slots and bits beyond WIDTH
      start_stream();
      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].l_tx, vecs[v].r_tx, vecs[v].nbits);
         p.l = vecs[v].l_exp;
         p.r = vecs[v].r_exp;
         exp_q.push_back(p);
      end
      flush();
      drain("table", ERR_EN ? 4 : 0);

      // Ten back-to-back frames with incrementing data
      rst_cycle();
      start_stream();
      for (int k = 0; k < 10; k++) push_frame(24'h100000 + 24'(k), 24'hF00000 - 24'(k));
      flush();
      drain("burst", 0);

      // Reset released with lrclk high in the middle of a right slot
      @(negedge clk);
      rstn  = 1'b0;
      carry = 1'b1;
      for (int i = 0; i < 10; i++) send_bit(1'b1, i[0]);
      check("rst_mid_right_left", sample_left, 0);
      check("rst_mid_right_right", sample_right, 0);
      rstn = 1'b1;
      mark_phase();
      for (int i = 0; i < 22; i++) send_bit(1'b1, ~i[0]);
      carry = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rl = 24'($urandom);
         rr = 24'($urandom);
         push_frame(rl, rr);
      end
      flush();
      drain("rst_right", 0);

      // Reset pulsed mid-left-slot
      rst_cycle();
      start_stream();
      push_frame(24'h13579B, 24'h2468AC);
      for (int i = 0; i < 8; i++) send_bit(1'b0, (i == 0) ? carry : 1'b1);
      check("hold_left", sample_left, 24'h13579B);
      check("hold_right", sample_right, 24'h2468AC);
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_left_left", sample_left, 0);
      check("rst_mid_left_right", sample_right, 0);
      check("rst_mid_left_valid", sample_valid, 0);
      rstn = 1'b1;
      for (int i = 0; i < 24; i++) send_bit(1'b0, i[1]);
      for (int i = 0; i < 32; i++) send_bit(1'b1, i[0]);
      carry = 1'b1;
      push_frame(24'hC0FFEE, 24'h0BADF0);
      push_frame(24'h000001, 24'hFFFFFE);
      flush();
      drain("rst_left", 0);

      // Latency from the registered sclk edge at the 1 -> 0 change
      rst_cycle();
      start_stream();
      push_frame(24'h55AA33, 24'hCC0F0F);
      sclk  = 1'b0;
      lrclk = 1'b0;
      sd    = carry;
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      check("latency_e3", sample_valid, 0);
      @(posedge clk);
      #1;
      check("latency_e4", sample_valid, 1);
      @(posedge clk);
      #1;
      check("latency_e5", sample_valid, 0);
      repeat (3) @(negedge clk);
      send_bit(1'b0, 1'b0);
      repeat (10) @(negedge clk);
      drain("latency", 0);

      check("valid_width", max_run, 1);
      $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
      $finish;
   end

endmodule
